// File: rtl/ladybug_pkg.sv
// Shared types and constants for the ladybug ROM download path: FSM states,
// default region map and one-hot chip-select codes.
package ladybug_pkg;

  typedef enum logic [2:0] {
    EMPTY,
    LOAD,
    CHECK,
    HOLD,
    RUN,
    ERROR
  } dl_state_t;

  localparam logic [15:0] ROM_SIZE_DEF = 16'hE000;
  localparam logic [15:0] R1_BASE_DEF  = 16'h6000;
  localparam logic [15:0] R2_BASE_DEF  = 16'h8000;
  localparam logic [15:0] R3_BASE_DEF  = 16'hC000;

  localparam logic [3:0] CS_NONE = 4'b0000;
  localparam logic [3:0] CS_CPU  = 4'b0001;
  localparam logic [3:0] CS_GFX  = 4'b0010;
  localparam logic [3:0] CS_SPR  = 4'b0100;
  localparam logic [3:0] CS_PROM = 4'b1000;

  // Region and size compares are done 17 bits wide so a 64 KiB bound never wraps.
  function automatic logic [16:0] ext17(input logic [15:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/dl_region_dec.sv
// Combinational ioctl address decode: one-hot region select plus an in-range
// flag that is low for any address at or beyond the image size.
module dl_region_dec
  import ladybug_pkg::*;
#(
  parameter logic [15:0] ROM_SIZE = ROM_SIZE_DEF,
  parameter logic [15:0] R1_BASE  = R1_BASE_DEF,
  parameter logic [15:0] R2_BASE  = R2_BASE_DEF,
  parameter logic [15:0] R3_BASE  = R3_BASE_DEF
) (
  input  logic [24:0] addr,
  output logic [3:0]  cs,
  output logic        in_range
);

  logic [16:0] addr17;

  always_comb begin
    addr17   = {1'b0, addr[15:0]};
    // Any bit above 64 KiB is out of range regardless of the low half.
    in_range = (addr[24:16] == 9'd0) && (addr17 < ext17(ROM_SIZE));
    if (addr17 < ext17(R1_BASE)) begin
      cs = CS_CPU;
    end else if (addr17 < ext17(R2_BASE)) begin
      cs = CS_GFX;
    end else if (addr17 < ext17(R3_BASE)) begin
      cs = CS_SPR;
    end else begin
      cs = CS_PROM;
    end
  end

endmodule

// File: rtl/ladybug_dl_ctrl.sv
// ROM download sequencer: registers accepted ioctl bytes toward the core with
// a region select, size-checks the image and owns the core reset.
module ladybug_dl_ctrl
  import ladybug_pkg::*;
#(
  parameter logic [15:0] ROM_SIZE = ROM_SIZE_DEF,
  parameter logic [15:0] R1_BASE  = R1_BASE_DEF,
  parameter logic [15:0] R2_BASE  = R2_BASE_DEF,
  parameter logic [15:0] R3_BASE  = R3_BASE_DEF,
  parameter int          RST_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ext_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [3:0]  dn_cs,
  output logic        core_reset,
  output logic        rom_ok,
  output logic        rom_err
);

  localparam logic [15:0] HOLD_LOAD = 16'(RST_HOLD - 1);

  dl_state_t   state;
  logic [16:0] max_addr;
  logic        ovf;
  logic        dl_prev;
  logic [15:0] hold_cnt;

  logic [3:0]  dec_cs;
  logic        in_range;
  logic        byte_strobe;
  logic        accept;
  logic        reject;
  logic        load_start;
  logic        pass;
  logic [16:0] next_max;

  dl_region_dec #(
    .ROM_SIZE (ROM_SIZE),
    .R1_BASE  (R1_BASE),
    .R2_BASE  (R2_BASE),
    .R3_BASE  (R3_BASE)
  ) u_dec (
    .addr     (ioctl_addr),
    .cs       (dec_cs),
    .in_range (in_range)
  );

  always_comb begin
    byte_strobe = (state == LOAD) && ioctl_wr && ioctl_download;
    accept      = byte_strobe && in_range;
    reject      = byte_strobe && !in_range;
    next_max    = {1'b0, ioctl_addr[15:0]} + 17'd1;
    pass        = !ovf && (max_addr == ext17(ROM_SIZE));
    // From EMPTY only a fresh rising edge starts a load, so a download cut
    // short by reset cannot resume mid-stream.
    load_start  = ((state == EMPTY) && ioctl_download && !dl_prev) ||
                  (((state == RUN) || (state == ERROR)) && ioctl_download);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      max_addr   <= '0;
      ovf        <= 1'b0;
      dl_prev    <= 1'b1;
      hold_cnt   <= '0;
      dn_addr    <= '0;
      dn_data    <= '0;
      dn_wr      <= 1'b0;
      dn_cs      <= CS_NONE;
      core_reset <= 1'b1;
      rom_ok     <= 1'b0;
      rom_err    <= 1'b0;
    end else begin
      dl_prev <= ioctl_download;
      dn_wr   <= 1'b0;
      dn_cs   <= CS_NONE;

      if (accept) begin
        dn_wr   <= 1'b1;
        dn_addr <= ioctl_addr[15:0];
        dn_data <= ioctl_dout;
        dn_cs   <= dec_cs;
        if (next_max > max_addr) begin
          max_addr <= next_max;
        end
      end
      if (reject) begin
        ovf <= 1'b1;
      end

      if (load_start) begin
        state      <= LOAD;
        max_addr   <= '0;
        ovf        <= 1'b0;
        rom_ok     <= 1'b0;
        rom_err    <= 1'b0;
        core_reset <= 1'b1;
      end else begin
        case (state)
          LOAD: begin
            // Verdict is latched as CHECK is entered so it is visible during CHECK.
            if (!ioctl_download) begin
              state   <= CHECK;
              rom_ok  <= pass;
              rom_err <= !pass;
            end
          end
          CHECK: begin
            if (rom_ok) begin
              state    <= HOLD;
              hold_cnt <= HOLD_LOAD;
            end else begin
              state <= ERROR;
            end
          end
          HOLD: begin
            if (ext_reset) begin
              hold_cnt <= HOLD_LOAD;
            end else if (hold_cnt == 16'd0) begin
              state      <= RUN;
              core_reset <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - 16'd1;
            end
          end
          RUN: begin
            if (ext_reset) begin
              state      <= HOLD;
              hold_cnt   <= HOLD_LOAD;
              core_reset <= 1'b1;
            end
          end
          EMPTY, ERROR: begin
            core_reset <= 1'b1;
          end
          default: begin
            state      <= EMPTY;
            core_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ladybug_dl_ctrl.sv
// Directed-sequence bench for ladybug_dl_ctrl with randomized bytes and
// addresses, checked against a behavioural download/size model.
module tb_ladybug_dl_ctrl;

  localparam int ROM  = 'hE000;
  localparam int HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ext_reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [3:0]  dn_cs;
  logic        core_reset;
  logic        rom_ok;
  logic        rom_err;

  int checks   = 0;
  int failures = 0;
  int dn_count = 0;

  bit m_loading = 1'b0;
  int m_max     = 0;
  bit m_ovf     = 1'b0;

  ladybug_dl_ctrl dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ext_reset      (ext_reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_cs          (dn_cs),
    .core_reset     (core_reset),
    .rom_ok         (rom_ok),
    .rom_err        (rom_err)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #3ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_cs(input int a);
    if (a < 'h6000) return 4'b0001;
    if (a < 'h8000) return 4'b0010;
    if (a < 'hC000) return 4'b0100;
    return 4'b1000;
  endfunction

  task automatic idle();
    @(posedge clk_sys); #1;
    check("dn_idle", 64'({dn_wr, dn_cs}), 64'd0);
  endtask

  task automatic wr_byte(input logic [24:0] a);
    logic [7:0] d;
    bit         acc;
    int         ai;
    ai  = int'(a);
    d   = 8'($urandom);
    acc = m_loading && ioctl_download && (ai < ROM);
    if (m_loading && ioctl_download) begin
      if (acc) begin
        if (ai + 1 > m_max) m_max = ai + 1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    if (acc)
      check("dn_write", 64'({dn_wr, dn_cs, dn_addr, dn_data}),
            64'({1'b1, ref_cs(ai), a[15:0], d}));
    else
      check("dn_drop", 64'({dn_wr, dn_cs}), 64'd0);
    if (dn_wr) dn_count++;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    m_loading = 1'b1;
    m_max     = 0;
    m_ovf     = 1'b0;
  endtask

  task automatic end_dl(input bit stray, input logic [24:0] saddr);
    bit pass;
    int n;
    ioctl_download = 1'b0;
    if (stray) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = saddr;
    end
    @(posedge clk_sys); #1;
    ioctl_wr  = 1'b0;
    m_loading = 1'b0;
    pass = !m_ovf && (m_max == ROM);
    check("dn_idle_on_fall", 64'({dn_wr, dn_cs}), 64'd0);
    check("rom_ok_at_check", 64'(rom_ok), 64'(pass));
    check("rom_err_at_check", 64'(rom_err), 64'(!pass));
    check("core_reset_in_check", 64'(core_reset), 64'd1);
    n = 1;
    while (core_reset === 1'b1 && n < 60) begin
      @(posedge clk_sys); #1;
      n++;
    end
    if (pass) check("release_latency", 64'(n), 64'(2 + HOLD));
    else      check("held_after_fail", 64'(core_reset), 64'd1);
  endtask

  task automatic load_sparse(input int nrand);
    start_dl();
    repeat (nrand) begin
      wr_byte(25'($urandom_range(0, ROM - 2)));
      if ($urandom_range(0, 3) == 0) idle();
    end
    wr_byte(25'(ROM - 1));
  endtask

  initial begin
    int n;
    reset          = 1'b1;
    ext_reset      = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    #1;
    check("reset_outputs", 64'({dn_wr, dn_cs, dn_addr, dn_data, rom_ok, rom_err}), 64'd0);
    check("reset_core_reset", 64'(core_reset), 64'd1);
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    repeat (3) idle();
    check("empty_holds_reset", 64'(core_reset), 64'd1);

    // full back-to-back image
    start_dl();
    dn_count = 0;
    for (int a = 0; a < ROM; a++) wr_byte(25'(a));
    check("full_dn_count", 64'(dn_count), 64'(ROM));
    end_dl(1'b0, '0);
    check("run_after_full", 64'(core_reset), 64'd0);

    // external reset pulse while running
    ext_reset = 1'b1;
    @(posedge clk_sys); #1;
    check("ext_reset_asserts", 64'(core_reset), 64'd1);
    repeat (4) @(posedge clk_sys);
    #1 ext_reset = 1'b0;
    n = 0;
    while (core_reset === 1'b1 && n < 60) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check("ext_reset_release", 64'(n), 64'(HOLD));

    // region boundaries
    start_dl();
    wr_byte(25'h05FFF); wr_byte(25'h06000); wr_byte(25'h07FFF);
    wr_byte(25'h08000); wr_byte(25'h0BFFF); wr_byte(25'h0C000);
    wr_byte(25'(ROM - 1));
    end_dl(1'b0, '0);

    // short image; a strobe on the falling cycle must not complete it
    start_dl();
    repeat (20) wr_byte(25'($urandom_range(0, ROM - 3)));
    wr_byte(25'h0DFFE);
    end_dl(1'b1, 25'h0DFFF);
    check("short_err", 64'(rom_err), 64'd1);

    load_sparse(30);
    end_dl(1'b0, '0);

    // overflow beyond the image and beyond 64 KiB
    start_dl();
    repeat (10) wr_byte(25'($urandom_range(0, ROM - 2)));
    wr_byte(25'(ROM - 1));
    wr_byte(25'h0E000);
    end_dl(1'b0, '0);
    check("ovf_err", 64'(rom_err), 64'd1);
    start_dl();
    wr_byte(25'(ROM - 1));
    wr_byte(25'h10000);
    wr_byte(25'h10005);
    end_dl(1'b0, '0);
    check("ovf64k_err", 64'(rom_err), 64'd1);

    // ext_reset during a load has no effect on the verdict
    start_dl();
    repeat (10) wr_byte(25'($urandom_range(0, ROM - 2)));
    ext_reset = 1'b1;
    repeat (3) idle();
    ext_reset = 1'b0;
    wr_byte(25'(ROM - 1));
    end_dl(1'b0, '0);

    // async reset in the middle of a load
    start_dl();
    repeat (8) wr_byte(25'($urandom_range(0, 'h2FFF)));
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h03000;
    ioctl_dout = 8'($urandom);
    #2 reset = 1'b1;
    #1;
    m_loading = 1'b0;
    check("areset_core_reset", 64'(core_reset), 64'd1);
    check("areset_outputs", 64'({dn_wr, dn_cs, dn_addr, dn_data, rom_ok, rom_err}), 64'd0);
    #1 reset = 1'b0;
    ioctl_wr = 1'b0;
    @(posedge clk_sys); #1;
    for (int a = 'h3001; a < 'h3010; a++) wr_byte(25'(a));
    ioctl_download = 1'b0;
    repeat (4) idle();
    check("after_abort_core_reset", 64'(core_reset), 64'd1);
    check("after_abort_flags", 64'({rom_ok, rom_err}), 64'd0);
    load_sparse(25);
    end_dl(1'b0, '0);
    check("recovered_ok", 64'(rom_ok), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
